// File: rtl/matrix_op_sequencer.sv
// Sequences 2x2 matrix ADD/SUB (element-wise) and MUL (two-step MAC per element)
// over external A/B element memories, streaming results to a 4-entry register file.
module matrix_op_sequencer (
  input  logic        clk,
  input  logic        nrst,
  input  logic        start,
  input  logic [2:0]  opcode,
  input  logic [7:0]  a_data,
  input  logic [7:0]  b_data,
  output logic [1:0]  a_addr,
  output logic [1:0]  b_addr,
  output logic        res_we,
  output logic [1:0]  res_addr,
  output logic [15:0] res_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        ovf
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EW,
    S_MAC0,
    S_MAC1,
    S_DONE,
    S_ERR
  } state_t;

  state_t      state_reg, state_next;
  logic [2:0]  op_reg, op_next;
  logic [1:0]  idx_reg, idx_next;
  logic [15:0] acc_reg, acc_next;
  logic        ovf_reg, ovf_next;

  logic [15:0] prod;
  logic [16:0] mac_sum;
  logic [15:0] ew_sum;
  logic [15:0] ew_diff;

  assign prod    = {8'd0, a_data} * {8'd0, b_data};
  assign mac_sum = {1'b0, acc_reg} + {1'b0, prod};
  assign ew_sum  = {8'd0, a_data} + {8'd0, b_data};
  assign ew_diff = {8'd0, a_data} - {8'd0, b_data};

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_reg <= S_IDLE;
      op_reg    <= 3'd0;
      idx_reg   <= 2'd0;
      acc_reg   <= 16'd0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      op_reg    <= op_next;
      idx_reg   <= idx_next;
      acc_reg   <= acc_next;
      ovf_reg   <= ovf_next;
    end
  end

  // Outputs decode from the state register, so reset clears them without waiting for clk.
  always_comb begin
    state_next = state_reg;
    op_next    = op_reg;
    idx_next   = idx_reg;
    acc_next   = acc_reg;
    ovf_next   = ovf_reg;
    a_addr     = 2'd0;
    b_addr     = 2'd0;
    res_we     = 1'b0;
    res_addr   = 2'd0;
    res_data   = 16'd0;
    busy       = (state_reg != S_IDLE);
    done       = 1'b0;
    err        = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          op_next  = opcode;
          ovf_next = 1'b0;
          idx_next = 2'd0;
          case (opcode)
            OP_ADD, OP_SUB: state_next = S_EW;
            OP_MUL:         state_next = S_MAC0;
            default:        state_next = S_ERR;
          endcase
        end
      end
      S_EW: begin
        a_addr   = idx_reg;
        b_addr   = idx_reg;
        res_addr = idx_reg;
        res_we   = 1'b1;
        res_data = (op_reg == OP_SUB) ? ew_diff : ew_sum;
        idx_next = idx_reg + 2'd1;
        if (idx_reg == 2'd3) state_next = S_DONE;
      end
      S_MAC0: begin
        a_addr     = {idx_reg[1], 1'b0};
        b_addr     = {1'b0, idx_reg[0]};
        acc_next   = prod;
        state_next = S_MAC1;
      end
      S_MAC1: begin
        a_addr   = {idx_reg[1], 1'b1};
        b_addr   = {1'b1, idx_reg[0]};
        res_addr = idx_reg;
        res_we   = 1'b1;
        res_data = mac_sum[15:0];
        if (mac_sum[16]) ovf_next = 1'b1;
        idx_next   = idx_reg + 2'd1;
        state_next = (idx_reg == 2'd3) ? S_DONE : S_MAC0;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      S_ERR: begin
        err        = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign ovf = ovf_reg;

endmodule

// File: tb/tb_matrix_op_sequencer.sv
// Directed, table-driven bench for matrix_op_sequencer with hand-computed results,
// plus sequences for invalid opcode and reset during a MUL.
module tb_matrix_op_sequencer;

  logic        clk;
  logic        nrst;
  logic        start;
  logic [2:0]  opcode;
  logic [7:0]  a_data;
  logic [7:0]  b_data;
  logic [1:0]  a_addr;
  logic [1:0]  b_addr;
  logic        res_we;
  logic [1:0]  res_addr;
  logic [15:0] res_data;
  logic        busy;
  logic        done;
  logic        err;
  logic        ovf;

  logic [3:0][7:0] a_mem;
  logic [3:0][7:0] b_mem;

  int n_checks = 0;
  int n_fail   = 0;

  matrix_op_sequencer dut (
    .clk      (clk),
    .nrst     (nrst),
    .start    (start),
    .opcode   (opcode),
    .a_data   (a_data),
    .b_data   (b_data),
    .a_addr   (a_addr),
    .b_addr   (b_addr),
    .res_we   (res_we),
    .res_addr (res_addr),
    .res_data (res_data),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .ovf      (ovf)
  );

  assign a_data = a_mem[a_addr];
  assign b_data = b_mem[b_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]       op;
    logic [3:0][7:0]  a;
    logic [3:0][7:0]  b;
    logic [3:0][15:0] r;
    logic             ovf;
    int               lat;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".busy"},     32'(busy),     32'd0);
    check({tag, ".done"},     32'(done),     32'd0);
    check({tag, ".err"},      32'(err),      32'd0);
    check({tag, ".res_we"},   32'(res_we),   32'd0);
    check({tag, ".ovf"},      32'(ovf),      32'd0);
    check({tag, ".addrs"},    32'({a_addr, b_addr, res_addr}), 32'd0);
    check({tag, ".res_data"}, 32'(res_data), 32'd0);
  endtask

  // Caller must be positioned at a negedge; start is applied immediately.
  task automatic run_op(input int v);
    int         nw;
    int         done_cyc;
    int         first_cyc;
    int         wr_cyc[4];
    logic [1:0] wr_addr[4];
    logic [15:0] wr_data[4];
    logic       ovf_mid;
    logic       ovf_end;
    int         exp_cyc;
    nw = 0; done_cyc = 0; first_cyc = 0; ovf_mid = 1'bx; ovf_end = 1'bx;
    a_mem  = vecs[v].a;
    b_mem  = vecs[v].b;
    opcode = vecs[v].op;
    start  = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 14 && done_cyc == 0; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 1) check($sformatf("v%0d.busy_c1", v), 32'(busy), 32'd1);
      if (first_cyc != 0 && c == first_cyc + 1) ovf_mid = ovf;
      if (res_we) begin
        if (nw < 4) begin
          wr_cyc[nw]  = c;
          wr_addr[nw] = res_addr;
          wr_data[nw] = res_data;
        end
        nw++;
        if (nw == 1) first_cyc = c;
      end
      if (done) begin
        done_cyc = c;
        ovf_end  = ovf;
        check($sformatf("v%0d.err_with_done", v), 32'(err), 32'd0);
      end
    end
    check($sformatf("v%0d.done_cycle", v), 32'(done_cyc), 32'(vecs[v].lat));
    check($sformatf("v%0d.num_writes", v), 32'(nw), 32'd4);
    for (int k = 0; k < 4 && k < nw; k++) begin
      exp_cyc = (vecs[v].op == 3'b010) ? 2 * k + 2 : k + 1;
      check($sformatf("v%0d.w%0d.addr", v, k),  32'(wr_addr[k]), 32'(k));
      check($sformatf("v%0d.w%0d.data", v, k),  32'(wr_data[k]), 32'(vecs[v].r[k]));
      check($sformatf("v%0d.w%0d.cycle", v, k), 32'(wr_cyc[k]),  32'(exp_cyc));
    end
    check($sformatf("v%0d.ovf_after_first", v), 32'(ovf_mid), 32'(vecs[v].ovf));
    check($sformatf("v%0d.ovf_at_done", v),     32'(ovf_end), 32'(vecs[v].ovf));
    @(negedge clk);
    check($sformatf("v%0d.busy_after", v), 32'(busy), 32'd0);
    check($sformatf("v%0d.done_after", v), 32'(done), 32'd0);
    $display("vector %0d op=%0d done_cycle=%0d writes=%0d ovf=%0b", v, vecs[v].op, done_cyc, nw, ovf_end);
  endtask

  initial begin
    // Packed arrays list element 3 first, element 0 last.
    vecs[0] = '{3'b000, {8'd4, 8'd3, 8'd2, 8'd1}, {8'd40, 8'd30, 8'd20, 8'd10},
                {16'd44, 16'd33, 16'd22, 16'd11}, 1'b0, 5};
    vecs[1] = '{3'b001, {8'd7, 8'd200, 8'd0, 8'd5}, {8'd7, 8'd100, 8'd1, 8'd3},
                {16'h0000, 16'd100, 16'hFFFF, 16'h0002}, 1'b0, 5};
    vecs[2] = '{3'b010, {8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5},
                {16'd50, 16'd43, 16'd22, 16'd19}, 1'b0, 9};
    vecs[3] = '{3'b010, {8'd255, 8'd255, 8'd255, 8'd255}, {8'd255, 8'd255, 8'd255, 8'd255},
                {16'hFC02, 16'hFC02, 16'hFC02, 16'hFC02}, 1'b1, 9};
    vecs[4] = '{3'b000, {8'd255, 8'd255, 8'd255, 8'd255}, {8'd255, 8'd255, 8'd255, 8'd255},
                {16'h01FE, 16'h01FE, 16'h01FE, 16'h01FE}, 1'b0, 5};
    vecs[5] = '{3'b010, {8'd3, 8'd1, 8'd0, 8'd2}, {8'd2, 8'd0, 8'd1, 8'd4},
                {16'd7, 16'd4, 16'd2, 16'd8}, 1'b0, 9};

    nrst = 1'b0; start = 1'b0; opcode = 3'd0;
    a_mem = '0; b_mem = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    $display("reset state checked");
    nrst = 1'b1;

    for (int v = 0; v < 6; v++) run_op(v);

    // Invalid opcode: one cycle of busy+err, no writes, then a normal ADD.
    start = 1'b1; opcode = 3'b101;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("err.busy_c1",  32'(busy),   32'd1);
    check("err.err_c1",   32'(err),    32'd1);
    check("err.we_c1",    32'(res_we), 32'd0);
    check("err.done_c1",  32'(done),   32'd0);
    @(negedge clk);
    check("err.busy_c2",  32'(busy),   32'd0);
    check("err.err_c2",   32'(err),    32'd0);
    $display("invalid opcode sequence checked");
    run_op(0);

    // MUL with start held high (must be ignored), then async reset mid-operation.
    a_mem = vecs[2].a; b_mem = vecs[2].b;
    start = 1'b1; opcode = 3'b010;
    @(posedge clk);
    @(negedge clk);
    opcode = 3'b000;
    @(negedge clk);
    check("rst.w0_we",   32'(res_we),   32'd1);
    check("rst.w0_data", 32'(res_data), 32'd19);
    @(negedge clk);
    @(negedge clk);
    check("rst.w1_addr", 32'(res_addr), 32'd1);
    check("rst.w1_data", 32'(res_data), 32'd22);
    start = 1'b0;
    #2 nrst = 1'b0;
    #1 check_idle("rst.async");
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle("rst.held");
    nrst = 1'b1;
    $display("reset during MUL checked");
    run_op(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/matrix_op_sequencer.md
MATRIX_OP_SEQUENCER -- requirements
Module: matrix_op_sequencer

Interface
REQ-001 SHALL have port clk, input, 1, rising-edge system clock.
REQ-002 SHALL have port nrst, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port start, input, 1, request to run one operation; sampled only in IDLE.
REQ-004 SHALL have port opcode, input, 3, operation select: 000 ADD, 001 SUB, 010 MUL; all others are invalid.
REQ-005 SHALL have port a_data, input, 8, unsigned element of matrix A, combinationally valid for a_addr in the same cycle.
REQ-006 SHALL have port b_data, input, 8, unsigned element of matrix B, combinationally valid for b_addr in the same cycle.
REQ-007 SHALL have port a_addr, output, 2, A element address {row,col}.
REQ-008 SHALL have port b_addr, output, 2, B element address {row,col}.
REQ-009 SHALL have port res_we, output, 1, result register file write enable.
REQ-010 SHALL have port res_addr, output, 2, result element address {row,col}.
REQ-011 SHALL have port res_data, output, 16, result element value.
REQ-012 SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-013 SHALL have port done, output, 1, one-cycle pulse on successful completion.
REQ-014 SHALL have port err, output, 1, one-cycle pulse on invalid opcode.
REQ-015 SHALL have port ovf, output, 1, sticky MUL overflow flag for the last operation.

Function
REQ-016 SHALL implement states IDLE, EW, MAC0, MAC1, DONE and ERR.
REQ-017 SHALL, in IDLE with start=1, latch opcode, clear ovf, and go to EW (ADD/SUB), MAC0 (MUL) or ERR (invalid).
REQ-018 SHALL ignore start in every state other than IDLE; no queuing.
REQ-019 SHALL keep a 2-bit element index idx={i,j}, cleared on an accepted start.
REQ-020 SHALL, in EW, drive a_addr=b_addr=res_addr=idx and res_we=1.
REQ-021 SHALL, in EW, drive res_data = zero-extended a_data+b_data for ADD, or a_data-b_data as 16-bit two's complement for SUB.
REQ-022 SHALL, in EW, increment idx each cycle and go to DONE after idx=3 (4 write cycles).
REQ-023 SHALL, in MAC0, drive a_addr={i,0}, b_addr={0,j}, res_we=0, and register acc <= a_data*b_data (16-bit).
REQ-024 SHALL, in MAC1, drive a_addr={i,1}, b_addr={1,j}, res_addr=idx, res_we=1, and res_data = (acc + a_data*b_data) mod 2^16.
REQ-025 SHALL set ovf in MAC1 when acc + a_data*b_data > 65535; ovf holds until the next accepted start or reset.
REQ-026 SHALL, in MAC1, increment idx; go to MAC0 if the old idx<3, else to DONE (8 cycles, 4 writes).
REQ-027 SHALL, in DONE, assert done=1 for one cycle, then return to IDLE.
REQ-028 SHALL, in ERR, assert err=1 for one cycle with no writes, then return to IDLE.
REQ-029 SHALL drive res_we=0 and a_addr/b_addr/res_addr/res_data=0 in IDLE, DONE and ERR.
REQ-030 SHALL never assert done and err in the same cycle.
REQ-031 SHALL make start-to-done latency 5 cycles for ADD/SUB and 9 cycles for MUL, counting the start-sampling edge as cycle 0.

Reset
REQ-032 SHALL, on nrst=0, immediately force state IDLE and idx, acc, ovf, busy, done, err and res_we to 0, regardless of clk.
REQ-033 SHALL, on reset mid-operation, issue no further writes; the aborted operation does not resume.
REQ-034 SHALL accept a start on the first rising edge after nrst deasserts.

Verification
REQ-035 ADD, A=[1,2,3,4], B=[10,20,30,40] -> writes 11,22,33,44 to addr 0..3 in cycles 1-4; done in cycle 5; ovf=0.
REQ-036 SUB, A[0]=5/B[0]=3 and A[1]=0/B[1]=1 -> res_data 0x0002 at addr 0, 0xFFFF at addr 1.
REQ-037 MUL, A=[1,2,3,4], B=[5,6,7,8] -> writes 19,22,43,50 to addr 0..3 in cycles 2,4,6,8; done in cycle 9.
REQ-038 MUL with all elements 255 -> every write 0xFC02; ovf=1 after the first write and held through done.
REQ-039 opcode=101 -> busy and err high only in cycle 1; no res_we; start with opcode 000 on the next edge runs normally.
REQ-040 start pulsed during MUL, then nrst pulsed low at cycle 4 -> start ignored; outputs 0 asynchronously; no further writes; a new ADD after reset completes per REQ-035.
